// File: rtl/lieat_general_lzc_expand.sv
// lieat_general_lzc_expand
//
// Inverse of the general leading-zero counter. It takes a 5-bit leading-zero
// count and an empty flag, and applies them to a 32-bit operand. A left shift
// normalizes the operand and a logical right shift denormalizes it. The block
// also rebuilds the leading-one one-hot vector and the leading-zero
// thermometer mask.
//
// The shifter is an iterative log-shifter. Its stages shift by 16, 8, 4, 2
// and 1, and STAGES_PER_CYCLE of them run on each clock. With L equal to
// ceil(5 / STAGES_PER_CYCLE), the result appears L cycles after the request
// is accepted. Both sides use a valid/ready handshake. The block holds only
// one request at a time.
//
// Parameters:
//   STAGES_PER_CYCLE  shift stages applied per clock, legal range 1..5
//
// Optional feature (compile-time macro LIEAT_LZC_EXPAND_BYPASS_EN):
//   When defined, a request whose effective count is zero skips every shift
//   stage. It spends one pass-through cycle, so its latency is 1.
//   When undefined, every request runs the full latency L.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   in_valid_i   request valid
//   in_ready_o   block can accept a request (IDLE only)
//   data_i       operand
//   cnt_i        leading-zero count
//   empty_i      LZC empty flag (forces effective count to 0)
//   dir_i        0 = left shift (normalize), 1 = logical right shift
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   data_o       shifted operand
//   onehot_o     leading-one position
//   zmask_o      leading-zero thermometer mask
//   busy_o       block is not IDLE

module lieat_general_lzc_expand #(
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] data_i,
  input  logic [4:0]  cnt_i,
  input  logic        empty_i,
  input  logic        dir_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] data_o,
  output logic [31:0] onehot_o,
  output logic [31:0] zmask_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] data_q;
  logic [31:0] onehot_q;
  logic [31:0] zmask_q;
  logic [4:0]  ecnt_q;
  logic        dir_q;
  // Index of the next shift stage to apply: 0 is the 16-bit stage and 4 is
  // the 1-bit stage. A value of 5 means no stages are left.
  logic [2:0]  idx_q;

  logic        accept;
  logic        last_group;
  logic [4:0]  ecnt_in;
  logic [31:0] onehot_in;
  logic [31:0] zmask_in;
  logic [2:0]  idx_start;
  logic [31:0] shifted;
  logic [4:0]  amt;

  assign accept     = in_valid_i & in_ready_o;
  assign last_group = (int'(idx_q) + STAGES_PER_CYCLE) >= 5;

  // Values fixed at accept time.
  always_comb begin
    ecnt_in   = empty_i ? 5'd0 : cnt_i;
    onehot_in = empty_i ? 32'd0 : (32'h8000_0000 >> cnt_i);
    // cnt_i = 0 gives ~32'hFFFF_FFFF = 0, so the mask is empty as required.
    zmask_in  = empty_i ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> cnt_i);
`ifdef LIEAT_LZC_EXPAND_BYPASS_EN
    // A zero count starts past the last stage. The single SHIFT cycle that
    // follows moves straight on to DONE, so out_valid_o rises after one edge.
    idx_start = (ecnt_in == 5'd0) ? 3'd5 : 3'd0;
`else
    idx_start = 3'd0;
`endif
  end

  // Apply the current group of stages. The loop unrolls into
  // STAGES_PER_CYCLE chained conditional shifters.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    shifted = data_q;
    amt     = 5'd0;
    for (int j = 0; j < STAGES_PER_CYCLE; j++) begin
      if (int'(idx_q) + j < 5) begin
        amt = 5'(16 >> (int'(idx_q) + j));
        if ((ecnt_q & amt) != 5'd0) begin
          shifted = dir_q ? (shifted >> amt) : (shifted << amt);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments, so
    // every flop samples values from before the edge.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_group) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers. After a transfer they keep their last values in IDLE
  // and change only when a new request is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= 32'd0;
      onehot_q <= 32'd0;
      zmask_q  <= 32'd0;
      ecnt_q   <= 5'd0;
      dir_q    <= 1'b0;
      idx_q    <= 3'd0;
    end else if (accept) begin
      data_q   <= data_i;
      onehot_q <= onehot_in;
      zmask_q  <= zmask_in;
      ecnt_q   <= ecnt_in;
      dir_q    <= dir_i;
      idx_q    <= idx_start;
    end else if (state_q == SHIFT) begin
      data_q <= shifted;
      if (!last_group) idx_q <= idx_q + 3'(STAGES_PER_CYCLE);
    end
  end

  assign data_o   = data_q;
  assign onehot_o = onehot_q;
  assign zmask_o  = zmask_q;

endmodule

// File: tb/tb_lieat_general_lzc_expand.sv
// Self-checking bench for lieat_general_lzc_expand (default parameters).
// Each request pushes its expected result onto a scoreboard. A monitor pops
// the scoreboard and compares whenever a transfer completes on the output.
// The main sequence checks handshake timing, latency, backpressure and reset.

module tb_lieat_general_lzc_expand;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] data_i;
  logic [4:0]  cnt_i;
  logic        empty_i;
  logic        dir_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] data_o;
  logic [31:0] onehot_o;
  logic [31:0] zmask_o;
  logic        busy_o;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] oh;
    logic [31:0] zm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  lieat_general_lzc_expand dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .cnt_i       (cnt_i),
    .empty_i     (empty_i),
    .dir_i       (dir_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .onehot_o    (onehot_o),
    .zmask_o     (zmask_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: direct shifts and masks built bit by bit.
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] c,
                                 input logic e, input logic dr);
    exp_t r;
    if (e) begin
      r.d  = d;
      r.oh = 32'd0;
      r.zm = 32'hFFFF_FFFF;
    end else begin
      r.d  = dr ? (d >> c) : (d << c);
      r.oh = 32'd0;
      r.oh[31 - int'(c)] = 1'b1;
      r.zm = 32'd0;
      for (int i = 0; i < int'(c); i++) r.zm[31 - i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] c, input logic e);
`ifdef LIEAT_LZC_EXPAND_BYPASS_EN
    if (e || c == 5'd0) return 1;
`endif
    return 5;
  endfunction

  // The monitor compares on the falling edge of every cycle in which a
  // transfer completes.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_valid_o, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_o", data_o, e.d);
        check("onehot_o", onehot_o, e.oh);
        check("zmask_o", zmask_o, e.zm);
      end
    end
  end

  // Present one request and wait for the accept edge. The caller must be
  // #1 after an edge with the DUT in IDLE.
  task automatic send(input logic [31:0] d, input logic [4:0] c, input logic e,
                      input logic dr, input bit keep);
    data_i     = d;
    cnt_i      = c;
    empty_i    = e;
    dir_i      = dr;
    in_valid_i = 1'b1;
    if (keep) sb.push_back(model(d, c, e, dr));
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    check("accept_busy", busy_o, 32'd1);
    check("accept_ready", in_ready_o, 32'd0);
  endtask

  // Count edges after the accept edge until out_valid_o appears, up to a limit.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid_o !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_timeout", out_valid_o, 32'd1);
  endtask

  // Full transaction with out_ready_i high. The valid pulse must last exactly
  // one cycle, and the block must be ready again afterwards.
  task automatic run(input logic [31:0] d, input logic [4:0] c, input logic e,
                     input logic dr);
    int lat;
    out_ready_i = 1'b1;
    send(d, c, e, dr, 1'b1);
    wait_valid(lat);
    check("latency", lat, exp_lat(c, e));
    @(posedge clk); #1;
    check("pulse_end_valid", out_valid_o, 32'd0);
    check("pulse_end_ready", in_ready_o, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    data_i      = 32'd0;
    cnt_i       = 5'd0;
    empty_i     = 1'b0;
    dir_i       = 1'b0;
    out_ready_i = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", out_valid_o, 32'd0);
    check("rst_ready", in_ready_o, 32'd1);
    check("rst_busy", busy_o, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_onehot", onehot_o, 32'd0);
    check("rst_zmask", zmask_o, 32'd0);

    // Normalize example.
    run(32'h0000_1234, 5'd19, 1'b0, 1'b0);
    // Denormalize boundary cnt = 31.
    run(32'h8000_0000, 5'd31, 1'b0, 1'b1);
    // Left shift cnt = 31, with no wrap.
    run(32'h0000_0001, 5'd31, 1'b0, 1'b0);
    // Empty request.
    run(32'h0000_0000, 5'd7, 1'b1, 1'b0);
    // Zero count passes the data through unchanged.
    run(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1);
    // Random patterns.
    for (int i = 0; i < 6; i++) begin
      run($urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 1)));
    end

    // Backpressure: the result must hold steady, and a second request
    // presented during DONE must be ignored.
    out_ready_i = 1'b0;
    send(32'h0000_00F0, 5'd24, 1'b0, 1'b0, 1'b1);
    wait_valid(lat);
    check("bp_latency", lat, 32'd5);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        data_i     = 32'h5555_5555;
        cnt_i      = 5'd1;
        in_valid_i = 1'b1;
      end
      if (i == 6) in_valid_i = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", out_valid_o, 32'd1);
      check("bp_ready", in_ready_o, 32'd0);
      check("bp_data", data_o, 32'hF000_0000);
      check("bp_onehot", onehot_o, 32'h0000_0080);
      check("bp_zmask", zmask_o, 32'hFFFF_FF00);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid_o, 32'd0);
    check("bp_release_ready", in_ready_o, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_o || busy_o) seen = 1'b1;
    end
    check("bp_no_second", seen, 32'd0);
    check("bp_sb_empty", sb.size(), 32'd0);

    // Reset two cycles after accept: the in-flight result is discarded.
    send(32'h0000_0001, 5'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", busy_o, 32'd0);
    check("mid_rst_ready", in_ready_o, 32'd1);
    check("mid_rst_valid", out_valid_o, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid_o) seen = 1'b1;
    end
    check("mid_rst_no_valid", seen, 32'd0);
    run(32'h0000_1234, 5'd19, 1'b0, 1'b0);

    // A request presented together with reset: reset wins.
    rst        = 1'b1;
    in_valid_i = 1'b1;
    data_i     = 32'h1;
    cnt_i      = 5'd4;
    @(posedge clk); #1;
    rst        = 1'b0;
    in_valid_i = 1'b0;
    check("rst_vs_valid_busy", busy_o, 32'd0);
    check("rst_vs_valid_ready", in_ready_o, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lieat_general_lzc_expand.md
Name: lieat_general_lzc_expand

Overview:
- Consumer/inverse of the general leading-zero counter: takes a 5-bit leading-zero count plus empty flag and applies it back onto a 32-bit operand.
- Normalizes the operand (left shift by count) or denormalizes it (right shift by count).
- Regenerates the leading-one one-hot and the leading-zero thermometer mask.
- Iterative log-shifter with valid/ready on both sides; sits behind the LZC in divider / clz-normalize paths of the pipeline.

Parameters:
- STAGES_PER_CYCLE, 1, shift stages (16,8,4,2,1) applied per clock; legal 1..5. Shift latency L = ceil(5/STAGES_PER_CYCLE).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid_i  input  1  request valid
- in_ready_o  output  1  block can accept a request
- data_i  input  32  operand
- cnt_i  input  5  leading-zero count (LZC cnt output)
- empty_i  input  1  LZC empty flag
- dir_i  input  1  0 = left shift (normalize), 1 = logical right shift (denormalize)
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- data_o  output  32  shifted operand
- onehot_o  output  32  leading-one position
- zmask_o  output  32  leading-zero thermometer mask
- busy_o  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state IDLE, out_valid_o=0, in_ready_o=1, busy_o=0, data_o/onehot_o/zmask_o = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o, capture data_i, dir_i, empty_i.
  - Capture effective count ecnt = empty_i ? 0 : cnt_i; go to SHIFT with stage index 0.
- SHIFT:
  - Each edge applies the next STAGES_PER_CYCLE stages, in order 16,8,4,2,1.
  - Stage k shifts by 2^(4-k) when ecnt[4-k]=1, in direction dir.
  - After the last stage, go to DONE.
- DONE:
  - out_valid_o=1; all outputs held stable until out_ready_i=1.
  - On out_valid_o & out_ready_i, go to IDLE; in_ready_o=1 the following cycle.
- Latency: accept edge E0, out_valid_o visible after edge E(L); with default parameter L=5.
- Throughput: one request per L+2 cycles when out_ready_i is held high.
- No overlap: in_ready_o=0 in SHIFT and DONE; in_valid_i ignored there, nothing captured.
- onehot_o and zmask_o are computed from the captured count and become valid with out_valid_o:
  - empty=1: onehot_o = 0, zmask_o = 32'hFFFF_FFFF.
  - Otherwise onehot_o = 32'h8000_0000 >> cnt.
  - Otherwise zmask_o has bits [31:32-cnt] set; zmask_o = 0 when cnt = 0.
- Shift rules: shifts are logical (zero fill); empty=1 gives data_o = captured data unchanged.
- cnt = 31 is legal in both directions, with no wrap; e.g. left 0x1 → 0x8000_0000.
- Reset mid-operation: rst in SHIFT or DONE forces IDLE and out_valid_o=0 on the same edge; any in-flight result is discarded.
- Simultaneous rst and in_valid_i: reset wins, nothing captured.
- data_o/onehot_o/zmask_o hold their last values in IDLE. They are meaningful only while out_valid_o=1.

Optional Feature:
- Macro: LIEAT_LZC_EXPAND_BYPASS_EN.
- Defined: a request with ecnt = 0 (cnt_i=0 or empty_i=1) skips SHIFT and goes IDLE→DONE. out_valid_o is visible after edge E1 (latency 1); outputs are identical to the non-bypass case.
- Undefined: every request goes through SHIFT with full latency L.

Test Plan:
- Reset: hold rst 2 cycles, then release → out_valid_o=0, in_ready_o=1, busy_o=0, data_o/onehot_o/zmask_o=0.
- Normalize: data 0x0000_1234, cnt 19, empty 0, dir 0, out_ready_i=1 → out_valid_o after exactly 5 cycles, data_o=0x91A0_0000, onehot_o=0x0000_1000, zmask_o=0xFFFF_E000; one-cycle valid pulse, then in_ready_o=1.
- Denormalize boundary: data 0x8000_0000, cnt 31, dir 1 → data_o=0x0000_0001, onehot_o=0x0000_0001, zmask_o=0xFFFF_FFFE.
- Backpressure: normalize request with out_ready_i=0 for 10 cycles, plus a second in_valid_i pulse during DONE → outputs stable, in_ready_o=0, second request not captured; out_ready_i=1 completes exactly one transfer.
- Reset mid-shift: assert rst 2 cycles after accept → next cycle state IDLE, out_valid_o never asserts, busy_o=0; a new request then completes normally.
- Empty: data 0, empty 1, cnt 7 → data_o=0, onehot_o=0, zmask_o=0xFFFF_FFFF. Latency 5 without LIEAT_LZC_EXPAND_BYPASS_EN; latency 1 with it, and the same for cnt_i=0.
